reg_cfg_seq: RTL and testbench

REG_CFG_SEQ -- requirements
Module: reg_cfg_seq

---
 rtl/reg_cfg_seq.sv | 156 +++++++++++++++
 tb/tb_reg_cfg_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/reg_cfg_seq.sv
// Register-bus init sequencer: replays a table of {CA, data} writes after reset or on start, muxing host access when idle.
// Optional readback compare compiled in with REG_CFG_SEQ_READBACK_EN (RDBK state, sticky err/err_addr).
module reg_cfg_seq #(
  parameter int TBL_AW = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [TBL_AW:0]   tbl_cnt,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [23:0]       tbl_data,
  input  logic              H_CSB,
  input  logic              H_WRB,
  input  logic [7:0]        H_CA,
  input  logic [15:0]       H_CD_in,
  output logic [15:0]       H_CD_out,
  output logic              H_ready,
  output logic              CSB,
  output logic              WRB,
  output logic [7:0]        CA,
  output logic [15:0]       CD_in,
  input  logic [15:0]       CD_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        err_addr
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WRITE = 3'd2,
`ifdef REG_CFG_SEQ_READBACK_EN
    RDBK  = 3'd3,
`endif
    CHECK = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [TBL_AW:0] DEPTH = (TBL_AW+1)'(2**TBL_AW);

  state_t          state, state_nxt;
  logic [TBL_AW:0] idx, idx_inc, cnt_clamp;
  logic [7:0]      ent_ca;
  logic [15:0]     ent_dat;

  // Index is one bit wider than the table address so a full table ends cleanly.
  assign cnt_clamp = (tbl_cnt > DEPTH) ? DEPTH : tbl_cnt;
  assign idx_inc   = idx + (TBL_AW+1)'(1);
  assign tbl_addr  = idx[TBL_AW-1:0];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = (cnt_clamp == '0) ? DONE : FETCH;
      FETCH: state_nxt = WRITE;
`ifdef REG_CFG_SEQ_READBACK_EN
      WRITE: state_nxt = RDBK;
      RDBK:  state_nxt = CHECK;
`else
      WRITE: state_nxt = CHECK;
`endif
      CHECK: state_nxt = (idx_inc < cnt_clamp) ? FETCH : DONE;
      DONE:  if (start) state_nxt = (cnt_clamp == '0) ? DONE : FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      idx     <= '0;
      ent_ca  <= '0;
      ent_dat <= '0;
    end else begin
      case (state)
        FETCH: begin
          ent_ca  <= tbl_data[23:16];
          ent_dat <= tbl_data[15:0];
        end
        CHECK:   idx <= idx_inc;
        DONE:    if (start) idx <= '0;
        default: ;
      endcase
    end
  end

`ifdef REG_CFG_SEQ_READBACK_EN
  logic [15:0] rd_dat;

  // err keeps the first failing address until the next Reset; start does not clear it.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rd_dat   <= '0;
      err      <= 1'b0;
      err_addr <= '0;
    end else begin
      if (state == RDBK) rd_dat <= CD_out;
      if (state == CHECK && rd_dat != ent_dat && !err) begin
        err      <= 1'b1;
        err_addr <= ent_ca;
      end
    end
  end
`else
  assign err      = 1'b0;
  assign err_addr = 8'h00;
`endif

  always_comb begin
    busy = 1'b0;
    case (state)
      FETCH, WRITE, CHECK: busy = 1'b1;
`ifdef REG_CFG_SEQ_READBACK_EN
      RDBK:                busy = 1'b1;
`endif
      default:             busy = 1'b0;
    endcase
  end

  assign done     = (state == DONE);
  assign H_ready  = !Reset && !busy;
  assign H_CD_out = busy ? 16'h0000 : CD_out;

  // Host pass-through is combinational when idle; the sequencer owns the bus while busy.
  always_comb begin
    CSB   = 1'b1;
    WRB   = 1'b1;
    CA    = 8'h00;
    CD_in = 16'h0000;
    if (!Reset) begin
      if (!busy) begin
        CSB   = H_CSB;
        WRB   = H_WRB;
        CA    = H_CA;
        CD_in = H_CD_in;
      end else if (state == WRITE) begin
        CSB   = 1'b0;
        WRB   = 1'b0;
        CA    = ent_ca;
        CD_in = ent_dat;
      end
`ifdef REG_CFG_SEQ_READBACK_EN
      else if (state == RDBK) begin
        CSB   = 1'b0;
        CA    = ent_ca;
      end
`endif
    end
  end

endmodule

// File: tb/tb_reg_cfg_seq.sv
// Directed bench for reg_cfg_seq with a simple echoing register model; adapts to the readback build option.
module tb_reg_cfg_seq;

`ifdef REG_CFG_SEQ_READBACK_EN
  localparam int PE = 4;
  localparam bit RB = 1'b1;
`else
  localparam int PE = 3;
  localparam bit RB = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset, start;
  logic [3:0]  tbl_cnt;
  logic [2:0]  tbl_addr;
  logic [23:0] tbl_data;
  logic        H_CSB, H_WRB;
  logic [7:0]  H_CA;
  logic [15:0] H_CD_in, H_CD_out;
  logic        H_ready, CSB, WRB;
  logic [7:0]  CA;
  logic [15:0] CD_in, CD_out;
  logic        busy, done, err;
  logic [7:0]  err_addr;

  logic [23:0] tbl [8];
  logic [15:0] mem [256];
  logic        corrupt;

  int n_chk = 0;
  int n_pass = 0;
  int nwr, wc0, wc1, dcyc, leak, hbad, cnt;
  logic [7:0]  ca0;
  logic [15:0] d0;

  always #5 Clk = ~Clk;

  reg_cfg_seq dut (
    .Clk(Clk), .Reset(Reset), .start(start), .tbl_cnt(tbl_cnt),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .H_CSB(H_CSB), .H_WRB(H_WRB), .H_CA(H_CA), .H_CD_in(H_CD_in),
    .H_CD_out(H_CD_out), .H_ready(H_ready),
    .CSB(CSB), .WRB(WRB), .CA(CA), .CD_in(CD_in), .CD_out(CD_out),
    .busy(busy), .done(done), .err(err), .err_addr(err_addr)
  );

  assign tbl_data = tbl[tbl_addr];
  assign CD_out   = (corrupt && CA == 8'h34) ? 16'h0000 : mem[CA];

  always @(posedge Clk)
    if (!CSB && !WRB) mem[CA] <= CD_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Cycle n is the state after the n-th rising edge; sampling happens on the falling edge.
  task automatic run_seq(input int budget, input bit inject);
    nwr = 0; wc0 = -1; wc1 = -1; dcyc = -1; leak = 0; hbad = 0; ca0 = 8'h00; d0 = 16'h0000;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(posedge Clk);
      @(negedge Clk);
      start = 1'b0;
      if (!CSB && !WRB) begin
        nwr++;
        if (nwr == 1) begin wc0 = cyc; ca0 = CA; d0 = CD_in; end
        if (nwr == 2) wc1 = cyc;
        if (CA == 8'h02) leak++;
      end
      if (busy && H_ready) hbad++;
      if (inject) begin
        if (cyc == 1) begin H_CSB = 1'b0; H_WRB = 1'b0; H_CA = 8'h02; H_CD_in = 16'h0001; end
        if (cyc == 3) start = 1'b1;
        if (cyc == 4) begin H_CSB = 1'b1; H_WRB = 1'b1; end
      end
      if (done) begin dcyc = cyc; break; end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 8; i++) tbl[i] = 24'h0;
    tbl[0] = {8'h0A, 16'h001E};
    tbl[1] = {8'h34, 16'h2710};
    Reset = 1'b1; start = 1'b0; tbl_cnt = 4'd2; corrupt = 1'b0;
    H_CSB = 1'b1; H_WRB = 1'b1; H_CA = 8'h00; H_CD_in = 16'h0000;
    repeat (2) @(negedge Clk);

    chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
    chk("rst_err", err, 0);         chk("rst_err_addr", err_addr, 0);
    chk("rst_csb", CSB, 1);         chk("rst_wrb", WRB, 1);
    chk("rst_ca", CA, 0);           chk("rst_cd_in", CD_in, 0);
    chk("rst_h_ready", H_ready, 0); chk("rst_tbl_addr", tbl_addr, 0);

    // Two-entry sequence with a clean register model
    Reset = 1'b0;
    run_seq(40, 1'b0);
    chk("seq_nwr", nwr, 2);
    chk("seq_wr0_cyc", wc0, 2);
    chk("seq_wr1_cyc", wc1, 2 + PE);
    chk("seq_wr0_ca", ca0, 8'h0A);
    chk("seq_wr0_dat", d0, 16'h001E);
    chk("seq_done_cyc", dcyc, 1 + 2 * PE);
    chk("seq_err", err, 0);
    chk("seq_mem34", mem[8'h34], 16'h2710);
    chk("seq_hready_busy", hbad, 0);

    // Readback corruption at CA 0x34, then a clean rerun keeps err sticky
    corrupt = 1'b1; start = 1'b1;
    run_seq(40, 1'b0);
    chk("bad_done_cyc", dcyc, 1 + 2 * PE);
    chk("bad_err", err, RB);
    chk("bad_err_addr", err_addr, RB ? 8'h34 : 8'h00);
    corrupt = 1'b0; start = 1'b1;
    run_seq(40, 1'b0);
    chk("sticky_err", err, RB);
    chk("sticky_err_addr", err_addr, RB ? 8'h34 : 8'h00);

    // Host write and a start pulse during busy are both dropped
    start = 1'b1;
    run_seq(40, 1'b1);
    chk("busy_host_leak", leak, 0);
    chk("busy_nwr", nwr, 2);
    chk("busy_start_ign", dcyc, 1 + 2 * PE);
    chk("busy_hready", hbad, 0);
    H_CSB = 1'b0; H_WRB = 1'b0; H_CA = 8'h02; H_CD_in = 16'h0001;
    #1;
    chk("host_csb", CSB, 0);     chk("host_wrb", WRB, 0);
    chk("host_ca", CA, 8'h02);   chk("host_cd_in", CD_in, 16'h0001);
    chk("host_ready", H_ready, 1);
    @(negedge Clk);
    H_WRB = 1'b1;
    #1;
    chk("host_rd", H_CD_out, 16'h0001);
    H_CSB = 1'b1;

    // Empty table
    @(negedge Clk);
    Reset = 1'b1; tbl_cnt = 4'd0;
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    chk("empty_done", done, 1);
    chk("empty_busy", busy, 0);
    chk("empty_hready", H_ready, 1);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (!CSB) cnt++;
      @(negedge Clk);
    end
    chk("empty_strobes", cnt, 0);

    // Oversized count clamps to the 8-entry table
    for (int i = 0; i < 8; i++) tbl[i] = {8'h40 + 8'(i), 16'h1000 + 16'(i * 16'h0111)};
    Reset = 1'b1; tbl_cnt = 4'd12;
    @(negedge Clk);
    Reset = 1'b0;
    run_seq(100, 1'b0);
    chk("full_nwr", nwr, 8);
    chk("full_done_cyc", dcyc, 1 + 8 * PE);
    chk("full_wr0_ca", ca0, 8'h40);
    chk("full_mem47", mem[8'h47], 16'h1777);

    // Reset in the middle of entry 5 aborts and restarts from entry 0
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 60 && cnt < 5; i++) begin
      @(negedge Clk);
      if (!CSB && !WRB) cnt++;
    end
    chk("abort_reached", cnt, 5);
    chk("abort_tbl_addr", tbl_addr, 3'd4);
    chk("abort_ca_pre", CA, 8'h44);
    Reset = 1'b1;
    #1;
    chk("abort_csb", CSB, 1);    chk("abort_wrb", WRB, 1);
    chk("abort_ca", CA, 0);      chk("abort_cd_in", CD_in, 0);
    chk("abort_busy", busy, 0);  chk("abort_hready", H_ready, 0);
    @(negedge Clk);
    Reset = 1'b0;
    run_seq(100, 1'b0);
    chk("restart_wr0_ca", ca0, 8'h40);
    chk("restart_wr0_cyc", wc0, 2);
    chk("restart_nwr", nwr, 8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
